bpsk_frame_mod: RTL

//  Parametrised BPSK/DBPSK frame modulator; next generation of the team's BPSK transmitter.

---
 rtl/bpsk_frame_mod_if.sv | 25 ++
 rtl/bpsk_frame_mod.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/bpsk_frame_mod_if.sv
// Control/status bundle for the BPSK frame modulator: frame request side and DAC sample side.
interface bpsk_frame_mod_if #(
  parameter int NWORDS = 16,
  parameter int WORD_W = 32
);
  logic                       start;
  logic                       abort;
  logic                       diff;
  logic [2:0]                 out_div;
  logic [NWORDS*WORD_W-1:0]   data;
  logic                       busy;
  logic                       done;
  logic                       tick;
  logic [7:0]                 out;

  modport master (
    output start, abort, diff, out_div, data,
    input  busy, done, tick, out
  );

  modport slave (
    input  start, abort, diff, out_div, data,
    output busy, done, tick, out
  );
endinterface

// File: rtl/bpsk_frame_mod.sv
// BPSK/DBPSK frame modulator: warm-up carrier, sync word, payload words and XOR checksum,
// one 20-sample carrier LUT stepped by a sample-tick enable in the single clk domain.
module bpsk_frame_mod #(
  parameter int                WORD_W      = 32,
  parameter int                NWORDS      = 16,
  parameter int                SYNC_W      = 64,
  parameter logic [SYNC_W-1:0] SYNC_PAT    = 64'hB5A6FFFF9BE37C39,
  parameter int                CLK_DIV     = 9,
  parameter int                CYC_PER_BIT = 2,
  parameter int                WARMUP_CYC  = 1000
) (
  input  logic              clk,
  input  logic              rst,
  bpsk_frame_mod_if.slave   bus
);
  localparam int TOT = SYNC_W + (NWORDS + 1) * WORD_W;
  localparam int TW  = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
  localparam int WW  = $clog2(WARMUP_CYC + 1);
  localparam int CW  = $clog2(CYC_PER_BIT + 1);
  localparam int SW  = $clog2(TOT + 1);

  typedef enum logic [2:0] {IDLE, WARM, SYNC, DATA, CSUM} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [4:0]      seq_q, seq_d;
  logic [TOT-1:0]  sr_q, sr_d;
  logic            diff_q, diff_d;
  logic            phase_q, phase_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [SW-1:0]   sym_q, sym_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [7:0]      out_q, out_d;

  logic            tick, cb, load, sym_bit;
  logic [7:0]      lut_v, shaped;

  // Payload is re-ordered so word 0 sits just below the sync word; the whole frame then
  // leaves MSB-first from one shift register.
  logic [NWORDS*WORD_W-1:0] ordered_w;
  logic [WORD_W-1:0]        csum_chain [NWORDS+1];

  assign csum_chain[0] = '0;
  for (genvar gi = 0; gi < NWORDS; gi++) begin : g_words
    assign ordered_w[(NWORDS-1-gi)*WORD_W +: WORD_W] = bus.data[gi*WORD_W +: WORD_W];
    assign csum_chain[gi+1] = csum_chain[gi] ^ bus.data[gi*WORD_W +: WORD_W];
  end

  function automatic logic [7:0] carrier_lut(input logic [4:0] idx);
    case (idx)
      5'd0:  carrier_lut = 8'd127;  5'd1:  carrier_lut = 8'd166;
      5'd2:  carrier_lut = 8'd202;  5'd3:  carrier_lut = 8'd230;
      5'd4:  carrier_lut = 8'd248;  5'd5:  carrier_lut = 8'd254;
      5'd6:  carrier_lut = 8'd248;  5'd7:  carrier_lut = 8'd230;
      5'd8:  carrier_lut = 8'd202;  5'd9:  carrier_lut = 8'd166;
      5'd10: carrier_lut = 8'd127;  5'd11: carrier_lut = 8'd88;
      5'd12: carrier_lut = 8'd52;   5'd13: carrier_lut = 8'd24;
      5'd14: carrier_lut = 8'd6;    5'd15: carrier_lut = 8'd0;
      5'd16: carrier_lut = 8'd6;    5'd17: carrier_lut = 8'd24;
      5'd18: carrier_lut = 8'd52;   default: carrier_lut = 8'd88;
    endcase
  endfunction

  assign tick = (tick_cnt_q == TW'(CLK_DIV));
  assign cb   = tick && (seq_q == 5'd19);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    seq_d      = tick ? ((seq_q == 5'd19) ? 5'd0 : seq_q + 5'd1) : seq_q;
    sr_d       = sr_q;
    diff_d     = diff_q;
    phase_d    = phase_q;
    wait_d     = wait_q;
    cyc_d      = cyc_q;
    sym_d      = sym_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    out_d      = out_q;
    load       = 1'b0;
    sym_bit    = sr_q[TOT-1];
    lut_v      = 8'd0;
    shaped     = 8'd0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sr_d    = {SYNC_PAT, ordered_w, csum_chain[NWORDS]};
          diff_d  = bus.diff;
          phase_d = 1'b0;
          wait_d  = '0;
          cyc_d   = '0;
          sym_d   = '0;
          busy_d  = 1'b1;
          state_d = WARM;
        end
      end
      WARM: begin
        if (cb) begin
          if (wait_q == WW'(WARMUP_CYC - 1)) load = 1'b1;
          else                               wait_d = wait_q + 1'b1;
        end
      end
      default: begin
        if (cb) begin
          if (cyc_q == CW'(CYC_PER_BIT - 1)) begin
            if (sym_q == SW'(TOT)) begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              load = 1'b1;
            end
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
      end
    endcase

    // The segment a symbol belongs to follows from how many symbols were sent before it.
    if (load) begin
      sr_d    = sr_q << 1;
      phase_d = diff_q ? (phase_q ^ sym_bit) : sym_bit;
      cyc_d   = '0;
      sym_d   = sym_q + 1'b1;
      if (sym_q < SW'(SYNC_W))                      state_d = SYNC;
      else if (sym_q < SW'(SYNC_W + NWORDS*WORD_W)) state_d = DATA;
      else                                          state_d = CSUM;
    end

    if (bus.abort && (state_q != IDLE)) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      out_d   = 8'd0;
    end else if (tick) begin
      lut_v  = carrier_lut(seq_d);
      shaped = phase_d ? (8'd254 - lut_v) : lut_v;
      out_d  = busy_d ? (shaped >> bus.out_div) : 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      seq_q      <= '0;
      sr_q       <= '0;
      diff_q     <= 1'b0;
      phase_q    <= 1'b0;
      wait_q     <= '0;
      cyc_q      <= '0;
      sym_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      out_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      seq_q      <= seq_d;
      sr_q       <= sr_d;
      diff_q     <= diff_d;
      phase_q    <= phase_d;
      wait_q     <= wait_d;
      cyc_q      <= cyc_d;
      sym_q      <= sym_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      out_q      <= out_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.tick = tick;
  assign bus.out  = out_q;
endmodule
